// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank.
package reg_bank_pkg;

  // Bank mode: normal access or clear sweep in progress.
  typedef enum logic {IDLE, CLEAR} state_t;

endpackage

// File: rtl/reg_bank_rd_port.sv
// One combinational read port: storage mux with optional write-through
// bypass of this cycle's accepted user writes and optional hard zero on r0.
module reg_bank_rd_port #(
  parameter int W       = 8,
  parameter int D       = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic [D-1:0]              raddr,
  input  logic [(2**D)-1:0][W-1:0]  regs,
  input  logic                      wrEnA,
  input  logic [D-1:0]              wrAddrA,
  input  logic [W-1:0]              wrDataA,
  input  logic                      wrEnB,
  input  logic [D-1:0]              wrAddrB,
  input  logic [W-1:0]              wrDataB,
  output logic [W-1:0]              rdData
);

  // Storage first, then same-cycle write data, then r0 zero wins over all.
  always_comb begin
    rdData = regs[raddr];
    if (BYPASS != 0) begin
      if (wrEnA && (wrAddrA == raddr))      rdData = wrDataA;
      else if (wrEnB && (wrAddrB == raddr)) rdData = wrDataB;
    end
    if ((ZERO_R0 != 0) && (raddr == '0)) rdData = '0;
  end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: NR read ports, paired write, optional zero r0,
// and a start-triggered sweep that clears one entry per clock.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int W       = 8,
  parameter int D       = 3,
  parameter int NR      = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  input  logic            write_en,
  input  logic            pair_en,
  input  logic [D-1:0]    waddr,
  input  logic [W-1:0]    data_inA,
  input  logic [W-1:0]    data_inB,
  input  logic [NR*D-1:0] raddr,
  output logic [NR*W-1:0] data_out,
  output logic            busy,
  output logic            write_drop
);

  localparam int DEPTH = 2**D;

  logic [DEPTH-1:0][W-1:0] regs;
  state_t                  state;
  logic [D-1:0]            sweepCnt;
  logic [D-1:0]            pairAddr;
  logic                    acceptWr;
  logic                    wrEnA;
  logic                    wrEnB;

  // A user write lands only in IDLE when no sweep is being requested;
  // r0 targets are dropped silently under ZERO_R0 without flagging a drop.
  assign pairAddr = waddr + 1'b1;
  assign acceptWr = (state == IDLE) && !start && write_en;
  assign wrEnA    = acceptWr && !((ZERO_R0 != 0) && (waddr == '0));
  assign wrEnB    = acceptWr && pair_en && !((ZERO_R0 != 0) && (pairAddr == '0));

  // Read ports share storage and the decoded write strobes.
  for (genvar i = 0; i < NR; i++) begin : gRd
    reg_bank_rd_port #(.W(W), .D(D), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) uRd (
      .raddr   (raddr[i*D +: D]),
      .regs    (regs),
      .wrEnA   (wrEnA),
      .wrAddrA (waddr),
      .wrDataA (data_inA),
      .wrEnB   (wrEnB),
      .wrAddrB (pairAddr),
      .wrDataB (data_inB),
      .rdData  (data_out[i*W +: W])
    );
  end

  // Sweep FSM, storage updates and registered status outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sweepCnt   <= '0;
      regs       <= '0;
      busy       <= 1'b0;
      write_drop <= 1'b0;
    end else begin
      write_drop <= write_en && !acceptWr;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            sweepCnt <= '0;
            busy     <= 1'b1;
          end else begin
            if (wrEnA) regs[waddr]    <= data_inA;
            if (wrEnB) regs[pairAddr] <= data_inB;
          end
        end
        CLEAR: begin
          regs[sweepCnt] <= '0;
          if (sweepCnt == '1) begin
            state    <= IDLE;
            sweepCnt <= '0;
            busy     <= 1'b0;
          end else begin
            sweepCnt <= sweepCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench: default bank (u0), zero-r0 bank (u1), no-bypass bank (u2),
// all driven from the same inputs.
module tb_reg_bank;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start, write_en, pair_en;
  logic [2:0]  waddr;
  logic [7:0]  dA, dB;
  logic [5:0]  raddr;
  logic [15:0] dOut0, dOut1, dOut2;
  logic        busy0, busy1, busy2;
  logic        drop0, drop1, drop2;

  int nCmp = 0;
  int nErr = 0;

  always #50 CLK = ~CLK;

  reg_bank #(.W(8), .D(3), .NR(2), .BYPASS(1), .ZERO_R0(0)) u0 (
    .CLK(CLK), .reset(reset), .start(start), .write_en(write_en), .pair_en(pair_en),
    .waddr(waddr), .data_inA(dA), .data_inB(dB), .raddr(raddr),
    .data_out(dOut0), .busy(busy0), .write_drop(drop0));

  reg_bank #(.W(8), .D(3), .NR(2), .BYPASS(1), .ZERO_R0(1)) u1 (
    .CLK(CLK), .reset(reset), .start(start), .write_en(write_en), .pair_en(pair_en),
    .waddr(waddr), .data_inA(dA), .data_inB(dB), .raddr(raddr),
    .data_out(dOut1), .busy(busy1), .write_drop(drop1));

  reg_bank #(.W(8), .D(3), .NR(2), .BYPASS(0), .ZERO_R0(0)) u2 (
    .CLK(CLK), .reset(reset), .start(start), .write_en(write_en), .pair_en(pair_en),
    .waddr(waddr), .data_inA(dA), .data_inB(dB), .raddr(raddr),
    .data_out(dOut2), .busy(busy2), .write_drop(drop2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setRd(input logic [2:0] a0, input logic [2:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  initial begin
    int n;
    logic [2:0] a1;
    reset = 1'b1; start = 0; write_en = 0; pair_en = 0;
    waddr = 0; dA = 0; dB = 0; raddr = 0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    chk("rst busy", busy0, 1'b0);
    chk("rst drop", drop0, 1'b0);
    for (int a = 0; a < 8; a++) begin
      setRd(3'(a), 3'(a));
      chk($sformatf("rst p0 r%0d", a), dOut0[7:0], 8'h00);
      chk($sformatf("rst p1 r%0d", a), dOut0[15:8], 8'h00);
    end

    // Wrapping pair write with same-cycle bypass
    write_en = 1; pair_en = 1; waddr = 3'd7; dA = 8'hAA; dB = 8'h55;
    setRd(3'd7, 3'd0);
    chk("pair byp p0", dOut0[7:0], 8'hAA);
    chk("pair byp p1", dOut0[15:8], 8'h55);
    chk("nobyp p0 old", dOut2[7:0], 8'h00);
    chk("nobyp p1 old", dOut2[15:8], 8'h00);
    tick();
    write_en = 0; pair_en = 0;
    setRd(3'd7, 3'd0);
    chk("pair st p0", dOut0[7:0], 8'hAA);
    chk("pair st p1", dOut0[15:8], 8'h55);
    chk("nobyp p0 new", dOut2[7:0], 8'hAA);
    chk("nobyp p1 new", dOut2[15:8], 8'h55);
    chk("pair drop", drop0, 1'b0);

    // Fill 0x11..0x88
    for (int k = 0; k < 8; k++) begin
      write_en = 1; waddr = 3'(k); dA = 8'(8'h11 * (k + 1));
      tick();
    end
    write_en = 0;

    // Sweep: busy for 8 samples, entries clear one per edge, mid-sweep write dropped
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("sw busy c%0d", c), busy0, 1'b1);
      if (c == 0) chk("sw drop c0", drop0, 1'b0);
      if (c == 3) chk("sw drop c3", drop0, 1'b1);
      if (c == 4) chk("sw drop c4", drop0, 1'b0);
      a1 = (c == 2) ? 3'd5 : 3'(c);
      if (c == 2) begin
        write_en = 1; waddr = 3'd5; dA = 8'hFF;
      end
      setRd((c > 0) ? 3'(c - 1) : 3'd0, a1);
      if (c > 0) chk($sformatf("sw cleared c%0d", c), dOut0[7:0], 8'h00);
      chk($sformatf("sw kept c%0d", c), dOut0[15:8], 8'(8'h11 * (a1 + 1)));
      tick();
      write_en = 0;
    end
    chk("sw end busy", busy0, 1'b0);
    for (int a = 0; a < 8; a++) begin
      setRd(3'(a), 3'(a));
      chk($sformatf("sw end r%0d", a), dOut0[7:0], 8'h00);
    end

    // First write after sweep is accepted
    write_en = 1; waddr = 3'd2; dA = 8'h22;
    setRd(3'd2, 3'd2);
    chk("post sw byp", dOut0[7:0], 8'h22);
    tick();
    write_en = 0;
    setRd(3'd2, 3'd2);
    chk("post sw st", dOut0[7:0], 8'h22);
    chk("post sw drop", drop0, 1'b0);

    // start and write in the same IDLE cycle
    start = 1; write_en = 1; waddr = 3'd3; dA = 8'h3C;
    setRd(3'd3, 3'd3);
    chk("st+wr no byp", dOut0[7:0], 8'h00);
    tick();
    start = 0; write_en = 0;
    chk("st+wr busy", busy0, 1'b1);
    chk("st+wr drop", drop0, 1'b1);
    n = 0;
    while (busy0 && n < 20) begin
      tick();
      n++;
    end
    chk("st+wr sweep len", n, 8);
    setRd(3'd3, 3'd2);
    chk("st+wr r3", dOut0[7:0], 8'h00);
    chk("st+wr r2", dOut0[15:8], 8'h00);

    // Zero r0 bank
    reset = 1; #2; reset = 0;
    write_en = 1; pair_en = 1; waddr = 3'd7; dA = 8'h12; dB = 8'h34;
    setRd(3'd7, 3'd0);
    chk("z byp r7", dOut1[7:0], 8'h12);
    chk("z byp r0", dOut1[15:8], 8'h00);
    chk("nz byp r0", dOut0[15:8], 8'h34);
    tick();
    write_en = 0; pair_en = 0;
    setRd(3'd7, 3'd0);
    chk("z st r7", dOut1[7:0], 8'h12);
    chk("z st r0", dOut1[15:8], 8'h00);
    chk("z drop", drop1, 1'b0);
    write_en = 1; waddr = 3'd0; dA = 8'h77;
    setRd(3'd7, 3'd0);
    chk("z wr0 byp", dOut1[15:8], 8'h00);
    tick();
    write_en = 0;
    setRd(3'd7, 3'd0);
    chk("z wr0 drop", drop1, 1'b0);
    chk("z wr0 st", dOut1[15:8], 8'h00);
    chk("nz wr0 st", dOut0[15:8], 8'h77);

    // Reset in the middle of a sweep
    write_en = 1; waddr = 3'd6; dA = 8'h66;
    tick();
    write_en = 0;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    chk("mid busy pre", busy0, 1'b1);
    reset = 1; #1;
    chk("mid busy rst", busy0, 1'b0);
    chk("mid drop rst", drop0, 1'b0);
    setRd(3'd6, 3'd7);
    chk("mid r6", dOut0[7:0], 8'h00);
    chk("mid r7", dOut0[15:8], 8'h00);
    reset = 0;
    tick();
    write_en = 1; waddr = 3'd4; dA = 8'h44;
    tick();
    write_en = 0;
    setRd(3'd4, 3'd4);
    chk("mid wr r4", dOut0[7:0], 8'h44);
    chk("mid wr drop", drop0, 1'b0);
    chk("mid wr busy", busy0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised successor to the processor's 8-bit, 8-entry register file. Adds NR combinational read ports with optional write-through bypass, a paired write (data_inB to waddr+1, wrapping), optional hard-wired zero register, and a start-triggered sequential clear sweep with busy/drop status. Sits between decode (addresses) and ALU/memory datapath (operands, results) in the basic processor.

## Interface
- W, 8, data width in bits
- D, 3, address width; depth = 2**D
- NR, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data
- ZERO_R0, 0, 1 = register 0 reads 0 and ignores all writes
- CLK  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; one clock domain (CLK)
- start  input  1  request a clear sweep; sampled only in IDLE
- write_en  input  1  write request
- pair_en  input  1  with write_en, also write data_inB to (waddr+1) mod 2**D
- waddr  input  D  primary write address
- data_inA  input  W  data for waddr
- data_inB  input  W  data for waddr+1
- raddr  input  NR×D  read addresses, port i at bits [i*D +: D]
- data_out  output  NR×W  read data, port i at bits [i*W +: W]
- busy  output  1  high while in CLEAR
- write_drop  output  1  registered one-cycle pulse: a write request was discarded

## Operation
- States: IDLE, CLEAR. Reset → IDLE, sweep counter 0, all registers 0, busy 0, write_drop 0.
- IDLE, start=1: → CLEAR, counter←0. If write_en also 1, the write is discarded and write_drop pulses next cycle.
- IDLE, start=0, write_en=1: registers[waddr]←data_inA; if pair_en, registers[(waddr+1) mod 2**D]←data_inB (waddr=2**D-1 wraps to 0).
- CLEAR: each edge registers[counter]←0, counter+1; after clearing 2**D-1 → IDLE, counter←0. start ignored. write_en=1 discarded, write_drop pulses next cycle.
- ZERO_R0=1: writes targeting address 0 (primary or pair) are suppressed silently (no write_drop); other half of a pair still written.
- Reads combinational: data_out[i]=registers[raddr[i]]. BYPASS=1 and an accepted user write targets raddr[i] this cycle → return that write's data (data_inA for waddr, data_inB for pair address). Clear writes are never bypassed. ZERO_R0=1 and raddr[i]=0 → 0, overriding bypass.
- No address collision possible within a pair (depth ≥ 2).
- reset mid-sweep: immediate return to IDLE, all registers 0.

## Timing
- Write latency: 1 edge to storage; 0 cycles to read ports with BYPASS=1, 1 cycle with BYPASS=0.
- Sweep: busy rises the cycle after start is sampled, stays high exactly 2**D cycles; first accepted write is the edge busy is sampled low.
- write_drop: high for the one cycle following the discarded request; back-to-back drops keep it high.
- busy and write_drop are registered; data_out is combinational from raddr, registers, write inputs.

## Structure
- Package reg_bank_pkg: state typedef enum logic {IDLE, CLEAR}; no other shared constants.
- Sub-module reg_bank_rd_port (W, D, BYPASS, ZERO_R0): one read mux with bypass/zero logic, instantiated NR times via generate.
- Top holds storage array, sweep FSM/counter, write decode, write_drop register.

## Test plan
- Reset then read all 8 addresses on both ports → all 0x00; busy=0, write_drop=0.
- write_en, pair_en, waddr=7, A=0xAA, B=0x55 → reg7=0xAA, reg0=0x55; same cycle raddr0=7, raddr1=0 read 0xAA/0x55 (BYPASS=1).
- Fill regs with 0x11..0x88, pulse start → busy high exactly 8 cycles, reg k reads 0 from cycle after its clear; write during sweep → write_drop one cycle, data unchanged.
- start and write_en same IDLE cycle (waddr=3, A=0x3C) → sweep runs, reg3 ends 0x00, write_drop pulses.
- ZERO_R0=1: pair write waddr=7, A=0x12, B=0x34 → reg7=0x12, raddr=0 reads 0x00, no write_drop.
- Assert reset at sweep cycle 4 → busy 0 immediately, all regs 0, next write accepted normally.
